can_bus_model: RTL and testbench
================================

CAN_BUS_MODEL -- requirements
Module: can_bus_model

Interface
REQ-001 Parameter NODES, default 4, number of CAN nodes attached to the bus (1..16).
REQ-002 Parameter BRP, default 8, clocks per bit time (4..64).
REQ-003 Parameter SAMPLE, default 5, prescaler count at which the bus is sampled (1..BRP-2).
REQ-004 Parameter ARB_BITS, default 12, non-stuff bits after SOF forming the arbitration field (11 ID + RTR).
REQ-005 clk  in  1  bus clock; all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 node_tx  in  NODES  per-node driven level; 0 = dominant, 1 = recessive.
REQ-008 bit_stuffing_EN  in  1  enables stuff-rule checking while in a frame.
REQ-009 bus_rx  out  1  wired-AND of node_tx, registered at the sample point.
REQ-010 bit_tick  out  1  one-cycle pulse in the cycle bus_rx updates.
REQ-011 sof  out  1  one-cycle pulse with bit_tick when a start-of-frame is sampled.
REQ-012 lost_arb  out  NODES  sticky per-node arbitration-loss flags.
REQ-013 stuff_err  out  1  one-cycle pulse with bit_tick on a stuff violation.
REQ-014 idle  out  1  high while the bus is idle.

Function
REQ-015 Prescaler counts 0..BRP-1 and wraps; bit_tick asserts when the count equals SAMPLE; bus_rx loads &node_tx in that cycle.
REQ-016 FSM states: IDLE, ARB, DATA; idle is high only in IDLE.
REQ-017 IDLE -> ARB on a sampled dominant bit; sof pulses; all lost_arb clear in that same cycle; run and arbitration counters restart.
REQ-018 In ARB, each sampled non-stuff bit increments the arbitration count; at ARB_BITS, ARB -> DATA.
REQ-019 In ARB, for each node with node_tx=1 while the sampled bus is 0, set lost_arb[n]; it stays set until the next SOF or reset.
REQ-020 Run counter tracks consecutive identical sampled bits in a frame, SOF included, saturating at 11.
REQ-021 After 5 identical bits, the next sampled bit is a stuff bit: not counted toward ARB_BITS; run restarts at 1 with its value.
REQ-022 If the stuff bit equals the previous five and bit_stuffing_EN=1: stuff_err pulses, FSM stays in frame, run restarts at 1.
REQ-023 With bit_stuffing_EN=0, stuff bits are not identified: all bits count, no stuff_err.
REQ-024 In ARB or DATA, 11 consecutive recessive sampled bits -> IDLE on the 11th bit_tick.
REQ-025 Simultaneous lost_arb set and SOF cannot occur; SOF clear has priority over any set in the same cycle.

Reset
REQ-026 On reset low, immediately: prescaler 0, FSM IDLE, counters 0, bus_rx=1, bit_tick=0, sof=0, stuff_err=0, lost_arb=0, idle=1.
REQ-027 Reset asserted mid-frame aborts the frame with no error pulse; after release, the first bit_tick occurs SAMPLE+1 clocks later.

Configuration
REQ-028 Macro CAN_BUS_HARD_SYNC_EN defined: in IDLE, a 1->0 transition of the unregistered wired-AND reloads the prescaler to 0 at the next clock edge, so bit_tick follows SAMPLE clocks later.
REQ-029 Macro undefined: the prescaler free-runs; no resynchronisation logic is present.

Verification (NODES=4, BRP=8, SAMPLE=5)
REQ-030 Reset pulse mid-frame -> bus_rx=1, idle=1, lost_arb=4'b0000, no pulses; first bit_tick 6 clocks after release.
REQ-031 Node0 sends ID 0x123, node1 sends 0x12F, RTR=0, nodes 2-3 recessive -> lost_arb=4'b0010, set at the ID3 bit_tick; bus_rx follows 0x123.
REQ-032 bit_stuffing_EN=1, SOF plus 5 dominant bits -> stuff_err pulses at the 6th dominant bit_tick; same stimulus with bit_stuffing_EN=0 -> no pulse.
REQ-033 SOF, 0,0,0,0, recessive stuff bit, then 11 ID bits, RTR -> ARB->DATA after the RTR bit, not one bit early.
REQ-034 After a frame, all nodes recessive -> idle rises on the 11th bit_tick; a dominant bit on the 10th -> no idle.
REQ-035 CAN_BUS_HARD_SYNC_EN defined, falling edge at prescaler count 3 in IDLE -> next bit_tick 6 clocks after the edge; undefined -> 2 clocks after.

Source files
------------

// File: rtl/can_bus_model.sv
// can_bus_model -- cycle-level model of a shared CAN bus.
//
// The wired-AND of all node drivers is sampled once per bit time. A small
// frame tracker follows SOF, the arbitration field and the data phase,
// flags nodes that lose arbitration, checks the bit-stuffing rule and
// detects the 11-recessive-bit return to idle.
//
// Optional feature: define CAN_BUS_HARD_SYNC_EN to let a recessive-to-
// dominant edge seen while idle restart the bit-time prescaler. Without
// the macro the prescaler free-runs.
//
// Sampling note: bus_rx, bit_tick, sof, stuff_err and the frame state are
// all registered on the same edge, the one that ends prescaler count
// SAMPLE-1. They are therefore visible during the cycle in which the
// prescaler reads SAMPLE.

module can_bus_model #(
  parameter int NODES    = 4,
  parameter int BRP      = 8,
  parameter int SAMPLE   = 5,
  parameter int ARB_BITS = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NODES-1:0] node_tx,
  input  logic             bit_stuffing_EN,
  output logic             bus_rx,
  output logic             bit_tick,
  output logic             sof,
  output logic [NODES-1:0] lost_arb,
  output logic             stuff_err,
  output logic             idle
);

  localparam int PW = (BRP > 1) ? $clog2(BRP) : 1;
  localparam int AW = $clog2(ARB_BITS + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(BRP - 1);
  localparam logic [PW-1:0] PRESC_SMP  = PW'(SAMPLE - 1);
  localparam logic [AW-1:0] ARB_LAST   = AW'(ARB_BITS - 1);
  localparam logic [3:0]    RUN_MAX    = 4'd11;
  localparam logic [3:0]    STUFF_RUN  = 4'd5;
  localparam logic [3:0]    REC_LAST   = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  state_e           state_q,     state_d;
  logic [PW-1:0]    presc_q,     presc_d;
  logic [3:0]       run_cnt_q,   run_cnt_d;
  logic             run_val_q,   run_val_d;
  logic [AW-1:0]    arb_cnt_q,   arb_cnt_d;
  logic [3:0]       rec_cnt_q,   rec_cnt_d;
  logic [NODES-1:0] active_q,    active_d;
  logic [NODES-1:0] lost_arb_q,  lost_arb_d;
  logic             bus_rx_q,    bus_rx_d;
  logic             bit_tick_q,  bit_tick_d;
  logic             sof_q,       sof_d;
  logic             stuff_err_q, stuff_err_d;

  logic wired_and;
  logic sample_pt;
  logic is_stuff;

  assign wired_and = &node_tx;
  assign sample_pt = (presc_q == PRESC_SMP);

`ifdef CAN_BUS_HARD_SYNC_EN
  logic wand_prev_q;
  logic hard_sync;

  // Remember the previous raw bus level to spot a 1->0 edge while idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wand_prev_q <= 1'b1;
    else        wand_prev_q <= wired_and;
  end

  assign hard_sync = (state_q == ST_IDLE) && wand_prev_q && !wired_and;

  // Prescaler: wraps at BRP-1, restarted by an idle-bus falling edge.
  always_comb begin
    presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
    if (hard_sync) presc_d = '0;
  end
`else
  // Prescaler: free-running 0..BRP-1.
  always_comb begin
    presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
  end
`endif

  // Frame tracker: next state, counters and output pulses per sampled bit.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    run_cnt_d   = run_cnt_q;
    run_val_d   = run_val_q;
    arb_cnt_d   = arb_cnt_q;
    rec_cnt_d   = rec_cnt_q;
    active_d    = active_q;
    lost_arb_d  = lost_arb_q;
    bus_rx_d    = bus_rx_q;
    bit_tick_d  = sample_pt;
    sof_d       = 1'b0;
    stuff_err_d = 1'b0;
    is_stuff    = 1'b0;

    if (sample_pt) begin
      bus_rx_d = wired_and;

      if (state_q == ST_IDLE) begin
        if (!wired_and) begin
          // Start of frame: nodes driving dominant now are the contenders.
          // Clearing lost_arb only happens here (IDLE) and setting only in
          // ARB, so a clear and a set can never collide.
          state_d    = ST_ARB;
          sof_d      = 1'b1;
          lost_arb_d = '0;
          active_d   = ~node_tx;
          run_cnt_d  = 4'd1;
          run_val_d  = 1'b0;
          arb_cnt_d  = '0;
          rec_cnt_d  = '0;
        end
      end else begin
        // A stuff bit follows five identical bits; >= also covers the
        // case where checking was just enabled after a longer run.
        is_stuff = bit_stuffing_EN && (run_cnt_q >= STUFF_RUN);

        if (is_stuff) begin
          if (wired_and == run_val_q) stuff_err_d = 1'b1;
          run_cnt_d = 4'd1;
          run_val_d = wired_and;
        end else begin
          if (wired_and == run_val_q) begin
            if (run_cnt_q < RUN_MAX) run_cnt_d = run_cnt_q + 4'd1;
          end else begin
            run_cnt_d = 4'd1;
            run_val_d = wired_and;
          end

          if (state_q == ST_ARB) begin
            arb_cnt_d = arb_cnt_q + 1'b1;
            if (arb_cnt_q == ARB_LAST) state_d = ST_DATA;
          end
        end

        // A contender sending recessive over a dominant bus has lost.
        if ((state_q == ST_ARB) && !wired_and)
          lost_arb_d = lost_arb_q | (active_q & node_tx);

        // Eleven recessive bits in a row end the frame, stuff bits or not.
        if (wired_and) begin
          if (rec_cnt_q == REC_LAST) state_d = ST_IDLE;
          if (rec_cnt_q < RUN_MAX)   rec_cnt_d = rec_cnt_q + 4'd1;
        end else begin
          rec_cnt_d = '0;
        end
      end
    end
  end

  // State register; reset drops any frame in progress without pulses.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop sees the pre-edge values regardless of statement order.
    if (!reset) begin
      state_q     <= ST_IDLE;
      presc_q     <= '0;
      run_cnt_q   <= '0;
      run_val_q   <= 1'b1;
      arb_cnt_q   <= '0;
      rec_cnt_q   <= '0;
      active_q    <= '0;
      lost_arb_q  <= '0;
      bus_rx_q    <= 1'b1;
      bit_tick_q  <= 1'b0;
      sof_q       <= 1'b0;
      stuff_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      run_cnt_q   <= run_cnt_d;
      run_val_q   <= run_val_d;
      arb_cnt_q   <= arb_cnt_d;
      rec_cnt_q   <= rec_cnt_d;
      active_q    <= active_d;
      lost_arb_q  <= lost_arb_d;
      bus_rx_q    <= bus_rx_d;
      bit_tick_q  <= bit_tick_d;
      sof_q       <= sof_d;
      stuff_err_q <= stuff_err_d;
    end
  end

  assign bus_rx    = bus_rx_q;
  assign bit_tick  = bit_tick_q;
  assign sof       = sof_q;
  assign stuff_err = stuff_err_q;
  assign lost_arb  = lost_arb_q;
  assign idle      = (state_q == ST_IDLE);

endmodule

// File: tb/tb_can_bus_model.sv
// tb_can_bus_model -- scoreboard bench for can_bus_model (NODES=4, BRP=8,
// SAMPLE=5). Stimulus drives one bit per bit time and queues the expected
// sampled response; a monitor pops and compares on every bit_tick.

module tb_can_bus_model;

  localparam int NODES  = 4;
  localparam int BRP    = 8;
  localparam int SAMPLE = 5;

`ifdef CAN_BUS_HARD_SYNC_EN
  localparam int HS_EXP = 6;
`else
  localparam int HS_EXP = 2;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [NODES-1:0] node_tx = 4'b1111;
  logic             bit_stuffing_EN = 1'b0;
  logic             bus_rx;
  logic             bit_tick;
  logic             sof;
  logic [NODES-1:0] lost_arb;
  logic             stuff_err;
  logic             idle;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       bus;
    logic       sof;
    logic       err;
    logic       idle;
    logic [3:0] lost;
    string      name;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  can_bus_model #(
    .NODES(NODES), .BRP(BRP), .SAMPLE(SAMPLE), .ARB_BITS(12)
  ) dut (
    .clk(clk),
    .reset(reset),
    .node_tx(node_tx),
    .bit_stuffing_EN(bit_stuffing_EN),
    .bus_rx(bus_rx),
    .bit_tick(bit_tick),
    .sof(sof),
    .lost_arb(lost_arb),
    .stuff_err(stuff_err),
    .idle(idle)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: compare at each bit_tick; outside ticks no pulse may appear.
  // Packed response is {bus_rx, sof, stuff_err, idle, lost_arb[3:0]}.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (bit_tick) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check(e.name, {24'd0, bus_rx, sof, stuff_err, idle, lost_arb},
                {24'd0, e.bus, e.sof, e.err, e.idle, e.lost});
        end
      end else begin
        check("pulse_off_tick", {30'd0, sof, stuff_err}, 32'd0);
      end
    end
  end

  // Step to just after the monitor has looked at the current tick period.
  task automatic align();
    @(negedge clk);
    #1;
  endtask

  // Wait for the next bit_tick, bounded to a few bit times.
  task automatic wait_tick();
    int k;
    for (k = 0; k < 4 * BRP; k++) begin
      @(posedge clk);
      #1;
      if (bit_tick) break;
    end
    if (k == 4 * BRP) begin
      n_checks++;
      n_fail++;
      $display("FAIL tick_timeout: got no bit_tick, expected one within %0d clocks", 4 * BRP);
    end
    align();
  endtask

  // Drive one bit and queue the response expected at its sample tick.
  task automatic send(input logic [3:0] tx, input logic b, input logic s,
                      input logic er, input logic id, input logic [3:0] lo,
                      input string nm);
    exp_t e;
    e.bus = b; e.sof = s; e.err = er; e.idle = id; e.lost = lo; e.name = nm;
    node_tx = tx;
    exp_q.push_back(e);
    wait_tick();
  endtask

  // Release reset and count clock periods, the first being the one right
  // after release, until bit_tick is seen: expected SAMPLE+1.
  task automatic release_and_time(input string nm);
    int n;
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (n = 1; n <= 4 * BRP; n++) begin
      @(posedge clk);
      #1;
      if (bit_tick) break;
    end
    check(nm, n + 1, SAMPLE + 1);
  endtask

  task automatic do_reset(input string nm);
    node_tx = 4'b1111;
    reset = 1'b0;
    @(posedge clk);
    release_and_time(nm);
  endtask

  initial begin
    logic [10:0] id0, id1;
    logic [14:0] s0, s1, s2;
    int n;

    id0 = 11'h123;
    id1 = 11'h12F;
    // SOF, ID10..7 = 0000, stuff 1, ID6..0 = 0101010, RTR, first data bit.
    s0 = 15'b0_0000_1_0101010_0_0;
    s1 = 15'b0_0000_1_0101010_1_0;  // node1 recessive at RTR
    s2 = 15'b0_0000_1_0101010_0_1;  // node2 recessive at first data bit

    #1 reset = 1'b0;
    #2;
    check("rst_bus_rx",    bus_rx,    1);
    check("rst_idle",      idle,      1);
    check("rst_lost_arb",  lost_arb,  0);
    check("rst_bit_tick",  bit_tick,  0);
    check("rst_sof",       sof,       0);
    check("rst_stuff_err", stuff_err, 0);
    release_and_time("rst_first_tick");
    align();

    // Arbitration 0x123 vs 0x12F; node1 loses at ID3, then idle detection.
    bit_stuffing_EN = 1'b0;
    send(4'b1100, 0, 1, 0, 0, 4'b0000, "a_sof");
    for (int i = 0; i < 11; i++)
      send({2'b11, id1[10-i], id0[10-i]}, id0[10-i], 0, 0, 0,
           (i >= 7) ? 4'b0010 : 4'b0000, $sformatf("a_id%0d", 10 - i));
    send(4'b1100, 0, 0, 0, 0, 4'b0010, "a_rtr");
    for (int i = 0; i < 9; i++)
      send(4'b1111, 1, 0, 0, 0, 4'b0010, $sformatf("b_rec%0d", i + 1));
    send(4'b1110, 0, 0, 0, 0, 4'b0010, "b_dom10");
    for (int i = 0; i < 11; i++)
      send(4'b1111, 1, 0, 0, (i == 10), 4'b0010, $sformatf("b_rec_run%0d", i + 1));
    send(4'b1111, 1, 0, 0, 1, 4'b0010, "b_idle_hold");

    // Stuff bit must not count toward the arbitration field length.
    bit_stuffing_EN = 1'b1;
    for (int i = 0; i < 15; i++)
      send({1'b1, s2[14-i], s1[14-i], s0[14-i]}, s0[14-i], (i == 0), 0, 0,
           (i >= 13) ? 4'b0010 : 4'b0000, $sformatf("c_bit%0d", i));

    // Reset in the middle of the data phase, with the bus held dominant.
    node_tx = 4'b1110;
    reset = 1'b0;
    #1;
    check("mid_rst_bus_rx",    bus_rx,    1);
    check("mid_rst_idle",      idle,      1);
    check("mid_rst_lost_arb",  lost_arb,  0);
    check("mid_rst_bit_tick",  bit_tick,  0);
    check("mid_rst_sof",       sof,       0);
    check("mid_rst_stuff_err", stuff_err, 0);
    node_tx = 4'b1111;
    release_and_time("mid_rst_first_tick");
    align();

    // Six dominant bits: stuff error only when checking is enabled.
    bit_stuffing_EN = 1'b1;
    send(4'b1110, 0, 1, 0, 0, 4'b0000, "d_sof");
    for (int i = 1; i < 5; i++)
      send(4'b1110, 0, 0, 0, 0, 4'b0000, $sformatf("d_dom%0d", i + 1));
    send(4'b1110, 0, 0, 1, 0, 4'b0000, "d_dom6_stuff_err");
    do_reset("d_rst_first_tick");
    align();

    bit_stuffing_EN = 1'b0;
    send(4'b1110, 0, 1, 0, 0, 4'b0000, "e_sof");
    for (int i = 1; i < 6; i++)
      send(4'b1110, 0, 0, 0, 0, 4'b0000, $sformatf("e_dom%0d", i + 1));
    do_reset("e_rst_first_tick");

    // Idle-bus falling edge during prescaler count 3 (tick period is 5).
    repeat (6) @(posedge clk);
    #1;
    node_tx = 4'b1110;
    for (n = 1; n <= 4 * BRP; n++) begin
      @(posedge clk);
      #1;
      if (bit_tick) break;
    end
    check("hard_sync_latency", n, HS_EXP);

    do_reset("final_rst_first_tick");
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
